iter_wide_mul: RTL
==================

// Module: iter_wide_mul
// PURPOSE
//  Multi-cycle unsigned WIDTH x WIDTH multiplier, result is 2*WIDTH bits.
//  Consumes operand b one DIGIT-bit slice per clock through a single
//  WIDTH x DIGIT partial-product multiplier, shifting each product into a
//  2*WIDTH accumulator. Trades latency for area in the wide-arithmetic
//  datapath. Start/done handshake; optional early exit on zero upper digits.
// PARAMETERS
//  WIDTH      1024  operand width in bits; must be a multiple of DIGIT
//  DIGIT      32    b-slice width multiplied per cycle
//  EARLY_EXIT 1     1: stop once the remaining b digits are all zero; 0: always N cycles
//  (derived) N = WIDTH/DIGIT digits; CNT_W = clog2(N)+1
// PORTS
//  clk    in   1        rising-edge clock
//  rst    in   1        synchronous, active-high reset
//  start  in   1        request; sampled only in IDLE or DONE
//  a      in   WIDTH    multiplicand, captured when start is accepted
//  b      in   WIDTH    multiplier, captured when start is accepted
//  busy   out  1        high while in RUN
//  done   out  1        one-cycle pulse; p is valid in that cycle
//  p      out  2*WIDTH  product; holds until the next accepted start
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, p=0, cnt=0,
//   a_reg=b_reg=0. Reset mid-RUN aborts the operation; no done pulse.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 -> a_reg<=a, b_reg<=b, acc<=0, cnt<=0, go to RUN.
//   RUN: at each edge
//    acc <= acc + ({a_reg*b_reg[DIGIT-1:0]} << (DIGIT*cnt)),
//    b_reg <= b_reg >> DIGIT, cnt <= cnt+1.
//    Leave for DONE when cnt==N-1,
//    or when EARLY_EXIT=1 and (b_reg >> DIGIT)==0.
//   DONE: done=1, p=acc.
//    start=1 -> accept as in IDLE and go to RUN (back-to-back).
//    Otherwise go to IDLE.
//  Start handling: start is ignored in RUN; operands are not re-sampled.
//  Latency: start sampled at edge E; RUN occupies cycles E+1..E+m;
//   done is high in cycle E+m+1.
//   m = N when EARLY_EXIT=0.
//   m = max(1, index of highest nonzero b digit + 1) when EARLY_EXIT=1.
//  Width rules:
//   Partial product a_reg*digit is WIDTH+DIGIT bits, zero-extended to
//   2*WIDTH before the shift.
//   The accumulator never overflows 2*WIDTH bits, because the result is
//   bounded by (2^WIDTH-1)^2.
//   All arithmetic is unsigned. Nothing is truncated or dropped.
//  p register: updated only on entry to DONE, so it is stable through
//   RUN of the following operation.
//  busy/done timing: busy and done are never high together.
//   busy=1 exactly in the m RUN cycles.
// TESTING
//  1 a=3, b=5, EARLY_EXIT=1 -> m=1 RUN cycle; done at E+2; p=15;
//    busy high for 1 cycle.
//  2 a=b=2^1024-1, EARLY_EXIT=1 -> m=32;
//    p = 2^2048 - 2^1025 + 1; done at E+33.
//  3 b=0, a=random -> m=1; p=0.
//    Same test with EARLY_EXIT=0: b=1 -> 32 RUN cycles, p=a.
//  4 b with only digit 31 nonzero (b=7<<992), a=9 -> m=32; p=63<<992.
//    start pulsed during RUN with other operands -> ignored, result unchanged.
//  5 start held high through DONE -> second op accepted with no IDLE
//    cycle; p holds the first result until the second done pulse.
//  6 rst=1 at RUN cycle 10 of a 32-digit op -> next cycle busy=0, done=0,
//    p=0. A fresh op after reset gives a correct product.
//  Scoreboard: 500 random (a,b) pairs against a reference model, covering
//   both EARLY_EXIT settings and DIGIT=16.

Source files
------------

// File: rtl/iter_wide_mul.sv
// Iterative unsigned WIDTH x WIDTH multiplier.
// Consumes one DIGIT-bit slice of b per clock into a 2*WIDTH accumulator.
module iter_wide_mul #(
  parameter int WIDTH      = 1024,
  parameter int DIGIT      = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(N) + 1;
  localparam int SH_W  = $clog2(2 * WIDTH);
  localparam int PP_W  = WIDTH + DIGIT;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PP_W-1:0]    pp;
  logic [2*WIDTH-1:0] pp_ext;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   b_nxt;
  logic               last;

  assign pp     = PP_W'(a_q) * PP_W'(b_q[DIGIT-1:0]);
  assign pp_ext = (2*WIDTH)'(pp);
  assign shamt  = SH_W'(cnt_q) * SH_W'(DIGIT);
  assign b_nxt  = b_q >> DIGIT;

  // Early exit once no nonzero digits remain above the current one.
  assign last = (cnt_q == CNT_W'(N - 1))
             || ((EARLY_EXIT != 0) && (b_nxt == '0));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RUN: begin
        acc_d = acc_q + (pp_ext << shamt);
        b_d   = b_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          state_d = S_DONE;
          p_d     = acc_d;
        end
      end
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign p    = p_q;

endmodule
